// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: forwards upstream bytes to the block processor, then
// appends 0x80, zero fill to block position 56 and the 64-bit big-endian bit length.
module sha256_msg_padder #(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       msg_empty,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       m_start,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_MSG   = 3'd2,
        S_PAD80 = 3'd3,
        S_ZERO  = 3'd4,
        S_LEN   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [5:0]       pos_q, pos_d;
    logic [2:0]       idx_q, idx_d;
    logic             empty_q, empty_d;
    logic             done_q, done_d;

    logic             xfer_s;
    logic [5:0]       pos_inc_s;
    logic [63:0]      len_s;

    // Selects byte idx of the length field, most significant byte first.
    function automatic logic [7:0] len_byte(input logic [63:0] len, input logic [2:0] idx);
        logic [63:0] sh;
        sh = len >> {3'd7 - idx, 3'b000};
        return sh[7:0];
    endfunction

    assign xfer_s    = m_valid && m_ready;
    assign pos_inc_s = pos_q + 6'd1;
    assign len_s     = 64'({count_q, 3'b000});
    assign done      = done_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            pos_q   <= 6'd0;
            idx_q   <= 3'd0;
            empty_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pos_q   <= pos_d;
            idx_q   <= idx_d;
            empty_q <= empty_d;
            done_q  <= done_d;
        end
    end

    // Next-state and counter updates; everything advances only on a downstream transfer.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pos_d   = pos_q;
        idx_d   = idx_q;
        empty_d = empty_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_START;
                    count_d = '0;
                    pos_d   = 6'd0;
                    idx_d   = 3'd0;
                    empty_d = msg_empty;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (empty_q) begin
                    state_d = S_PAD80;
                end else begin
                    state_d = S_MSG;
                end
            end
            S_MSG: begin
                if (xfer_s) begin
                    count_d = count_q + CNT_W'(1);
                    pos_d   = pos_inc_s;
                    if (s_last) begin
                        state_d = S_PAD80;
                    end else begin
                        state_d = S_MSG;
                    end
                end else begin
                    state_d = S_MSG;
                end
            end
            S_PAD80, S_ZERO: begin
                if (xfer_s) begin
                    pos_d = pos_inc_s;
                    if (pos_inc_s == 6'd56) begin
                        state_d = S_LEN;
                    end else begin
                        state_d = S_ZERO;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_LEN: begin
                if (xfer_s) begin
                    pos_d = pos_inc_s;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_LEN;
                    end
                end else begin
                    state_d = S_LEN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode; MSG is a pure pass-through so m_valid never depends on m_ready.
    always_comb begin
        s_ready = 1'b0;
        m_start = 1'b0;
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_last  = 1'b0;
        busy    = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_START: begin
                m_start = 1'b1;
            end
            S_MSG: begin
                m_data  = s_data;
                m_valid = s_valid;
                s_ready = m_ready;
            end
            S_PAD80: begin
                m_data  = 8'h80;
                m_valid = 1'b1;
            end
            S_ZERO: begin
                m_data  = 8'h00;
                m_valid = 1'b1;
            end
            S_LEN: begin
                m_data  = len_byte(len_s, idx_q);
                m_valid = 1'b1;
                m_last  = (idx_q == 3'd7);
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
